ad9866_gain_sequencer: RTL

- Upstream feeder for the AD9866 SPI controller.
- Accepts RX/TX gain writes from the host command path plus PTT, and holds each one as a pending update.
- Presents one request at a time on ext_rx_rqst/rx_gain or ext_tx_rqst/tx_gain, using sen_n from the SPI controller as the accept/done handshake.
- Guarantees the two requests are never asserted together and never re-trigger a transfer.

---
 rtl/ad9866_gain_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ad9866_gain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ad9866_gain_sequencer
//  Purpose  : Upstream feeder for the AD9866 SPI controller. Holds host RX/TX
//             gain writes as pending updates and presents them one at a time
//             on ext_rx_rqst/ext_tx_rqst. The controller's sen_n is used as
//             the accept (falling) and done (rising) handshake.
//  Options  : define GAIN_PTT_REFRESH_EN to force a refresh of the active
//             path gain on every T/R switch (ptt edge).
//  Revision : 1.0 - initial release
// ============================================================================
module ad9866_gain_sequencer #(
  parameter int unsigned HOLDOFF     = 4,      // idle cycles after a transfer, 1..15
  parameter int unsigned ACK_TIMEOUT = 4095,   // REQ cycles before withdraw/retry
  parameter logic [5:0]  RX_GAIN_RST = 6'h00,
  parameter logic [5:0]  TX_GAIN_RST = 6'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] rx_gain_in,
  input  logic       rx_gain_wr,
  input  logic [5:0] tx_gain_in,
  input  logic       tx_gain_wr,
  input  logic       ptt,
  input  logic       sen_n,
  output logic       ext_rx_rqst,
  output logic [5:0] rx_gain,
  output logic       ext_tx_rqst,
  output logic [5:0] tx_gain,
  output logic       busy,
  output logic       timeout_pulse
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_XFER = 2'd2;
  localparam logic [1:0] c_ST_GAP  = 2'd3;

  // Shared 12-bit counter: REQ wait time, then GAP hold-off time.
  localparam logic [11:0] c_ACK_LAST = 12'(ACK_TIMEOUT - 1);
  localparam logic [11:0] c_GAP_LAST = 12'(HOLDOFF - 1);

  // Value that can never match a real "already applied" compare at start-up.
  localparam logic [5:0]  c_APPLIED_RST = 6'h3F;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [11:0] r_cnt;
  logic        r_sel_tx;        // channel owning the current REQ/XFER
  logic [5:0]  r_rx_shadow;
  logic [5:0]  r_tx_shadow;
  logic [5:0]  r_rx_applied;    // last value the controller completed
  logic [5:0]  r_tx_applied;
  logic        r_rx_pend;
  logic        r_tx_pend;
  logic [5:0]  r_rx_gain;       // value presented to the controller
  logic [5:0]  r_tx_gain;
  logic        r_timeout_pulse;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [1:0]  w_state_nxt;
  logic        w_pick;          // IDLE selects a channel this cycle
  logic        w_pick_tx;       // ...and that channel is TX
  logic        w_timeout;       // REQ withdrawn this cycle
  logic        w_done;          // XFER completes this cycle
  logic        w_rx_inflight;
  logic        w_tx_inflight;
  logic        w_rx_pend_nxt;
  logic        w_tx_pend_nxt;
  logic        w_ptt_rise;
  logic        w_ptt_fall;

  // --------------------------------------------------------------------------
  // T/R switch edge detection (refresh option only)
  // --------------------------------------------------------------------------
`ifdef GAIN_PTT_REFRESH_EN
  logic r_ptt_q;

  // Register ptt so its edges can force a gain refresh.
  always_ff @(posedge clk) begin
    if (reset) r_ptt_q <= 1'b0;
    else       r_ptt_q <= ptt;
  end

  assign w_ptt_rise = ptt & ~r_ptt_q;
  assign w_ptt_fall = ~ptt & r_ptt_q;
`else
  assign w_ptt_rise = 1'b0;
  assign w_ptt_fall = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // Advance the sequencer state.
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // Arbitrate in IDLE, wait for accept/done, then hold off before re-arming.
  always_comb begin
    w_state_nxt = r_state;
    w_pick      = 1'b0;
    w_pick_tx   = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        // TX wins while transmitting, or whenever RX has nothing to send.
        if (r_tx_pend && (ptt || !r_rx_pend)) begin
          w_pick      = 1'b1;
          w_pick_tx   = 1'b1;
          w_state_nxt = c_ST_REQ;
        end else if (r_rx_pend) begin
          w_pick      = 1'b1;
          w_state_nxt = c_ST_REQ;
        end
      end
      c_ST_REQ: begin
        if (!sen_n) begin
          w_state_nxt = c_ST_XFER;
        end else if (r_cnt == c_ACK_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = c_ST_GAP;
        end
      end
      c_ST_XFER: begin
        if (sen_n) begin
          w_done      = 1'b1;
          w_state_nxt = c_ST_GAP;
        end
      end
      c_ST_GAP: begin
        if (r_cnt == c_GAP_LAST) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // Only the owning channel requests, and only until the controller drops sen_n.
  always_comb begin
    ext_rx_rqst = (r_state == c_ST_REQ) && !r_sel_tx && sen_n;
    ext_tx_rqst = (r_state == c_ST_REQ) &&  r_sel_tx && sen_n;
  end

  assign rx_gain       = r_rx_gain;
  assign tx_gain       = r_tx_gain;
  assign timeout_pulse = r_timeout_pulse;
  assign busy          = r_rx_pend | r_tx_pend | (r_state != c_ST_IDLE);

  // --------------------------------------------------------------------------
  // Pending-flag update
  // --------------------------------------------------------------------------
  // A channel counts as in flight from its IDLE selection until XFER ends, so
  // a write landing in that window always queues a follow-up transfer.
  assign w_rx_inflight = ((r_state == c_ST_REQ || r_state == c_ST_XFER) && !r_sel_tx)
                       || (w_pick && !w_pick_tx);
  assign w_tx_inflight = ((r_state == c_ST_REQ || r_state == c_ST_XFER) &&  r_sel_tx)
                       || (w_pick &&  w_pick_tx);

  // Clear on selection; writes, timeouts and T/R edges set (and so win).
  always_comb begin
    w_rx_pend_nxt = r_rx_pend;
    w_tx_pend_nxt = r_tx_pend;

    if (w_pick && !w_pick_tx) w_rx_pend_nxt = 1'b0;
    if (w_pick &&  w_pick_tx) w_tx_pend_nxt = 1'b0;

    if (rx_gain_wr && !((rx_gain_in == r_rx_applied) && !w_rx_inflight))
      w_rx_pend_nxt = 1'b1;
    if (tx_gain_wr && !((tx_gain_in == r_tx_applied) && !w_tx_inflight))
      w_tx_pend_nxt = 1'b1;

    if (w_timeout && !r_sel_tx) w_rx_pend_nxt = 1'b1;
    if (w_timeout &&  r_sel_tx) w_tx_pend_nxt = 1'b1;

    if (w_ptt_fall) w_rx_pend_nxt = 1'b1;
    if (w_ptt_rise) w_tx_pend_nxt = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // Shadows, presented gains, applied values, counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt           <= 12'd0;
      r_sel_tx        <= 1'b0;
      r_rx_shadow     <= RX_GAIN_RST;
      r_tx_shadow     <= TX_GAIN_RST;
      r_rx_applied    <= c_APPLIED_RST;
      r_tx_applied    <= c_APPLIED_RST;
      r_rx_pend       <= 1'b1;
      r_tx_pend       <= 1'b1;
      r_rx_gain       <= RX_GAIN_RST;
      r_tx_gain       <= TX_GAIN_RST;
      r_timeout_pulse <= 1'b0;
    end else begin
      if (rx_gain_wr) r_rx_shadow <= rx_gain_in;
      if (tx_gain_wr) r_tx_shadow <= tx_gain_in;

      r_rx_pend <= w_rx_pend_nxt;
      r_tx_pend <= w_tx_pend_nxt;

      // The presented gain is loaded only at selection, so it stays frozen
      // through REQ and XFER regardless of later host writes.
      if (w_pick) begin
        r_sel_tx <= w_pick_tx;
        if (w_pick_tx) r_tx_gain <= r_tx_shadow;
        else           r_rx_gain <= r_rx_shadow;
      end

      if (w_done) begin
        if (r_sel_tx) r_tx_applied <= r_tx_gain;
        else          r_rx_applied <= r_rx_gain;
      end

      r_timeout_pulse <= w_timeout;

      // Restart on every state change; count only where a limit is watched.
      if (w_state_nxt != r_state)
        r_cnt <= 12'd0;
      else if (r_state == c_ST_REQ || r_state == c_ST_GAP)
        r_cnt <= r_cnt + 12'd1;
    end
  end

endmodule
`default_nettype wire
